pll_lock_rst_seq: RTL and testbench

Lock supervisor and reset sequencer for the FCCC clock generator that produces GL0..GL3 from the 12.5 MHz input. It runs on the free-running reference clock and synchronises the asynchronous LOCK output. It holds every GL-domain reset until lock has been stable for a programmed time, then releases the domain resets one at a time in order. On loss of lock it re-asserts all domain resets, requests a PLL reset on lock timeout, and latches a fault after repeated failures.

---
 rtl/pll_ctrl_pkg.sv | 25 ++
 rtl/sync_2ff.sv | 28 ++
 rtl/pll_lock_rst_seq.sv | 186 ++++++++++++++++++
 tb/tb_pll_lock_rst_seq.sv | 215 +++++++++++++++++++++
 4 files changed

// File: rtl/pll_ctrl_pkg.sv
// Shared encodings and default timing for board clock/reset controllers.
// State values are fixed so debug tools can decode the STATE bus directly.
package pll_ctrl_pkg;

    typedef enum logic [2:0] {
        ST_WAIT_LOCK = 3'd0,
        ST_RELEASE   = 3'd1,
        ST_RUN       = 3'd2,
        ST_PLL_RST   = 3'd3,
        ST_FAULT     = 3'd4
    } pll_state_e;

    localparam int DEF_N_DOM            = 4;
    localparam int DEF_LOCK_STABLE_CYC  = 1024;
    localparam int DEF_STAGGER_CYC      = 16;
    localparam int DEF_LOCK_TIMEOUT_CYC = 65536;
    localparam int DEF_PLL_RST_CYC      = 8;
    localparam int DEF_MAX_RETRY        = 3;
    localparam int DEF_CNT_W            = 17;

    function automatic logic [7:0] sat_inc8(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

endpackage

// File: rtl/sync_2ff.sv
// Generic two-flop synchroniser for a single asynchronous level signal.
module sync_2ff #(
    parameter logic RST_VAL = 1'b0
) (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_d,
    output logic o_q
);

    logic r_meta;
    logic r_sync;

    // NOTE: reset is sampled on the clock edge, so it lives inside the
    // clocked branch rather than in the sensitivity list.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_meta <= RST_VAL;
            r_sync <= RST_VAL;
        end else begin
            r_meta <= i_d;
            r_sync <= r_meta;
        end
    end

    assign o_q = r_sync;

endmodule

// File: rtl/pll_lock_rst_seq.sv
// PLL lock supervisor: waits for stable lock, releases GL domain resets in
// order, re-asserts them on lock loss and retries the PLL up to a fault.
module pll_lock_rst_seq
    import pll_ctrl_pkg::*;
#(
    parameter int N_DOM            = DEF_N_DOM,
    parameter int LOCK_STABLE_CYC  = DEF_LOCK_STABLE_CYC,
    parameter int STAGGER_CYC      = DEF_STAGGER_CYC,
    parameter int LOCK_TIMEOUT_CYC = DEF_LOCK_TIMEOUT_CYC,
    parameter int PLL_RST_CYC      = DEF_PLL_RST_CYC,
    parameter int MAX_RETRY        = DEF_MAX_RETRY,
    parameter int CNT_W            = DEF_CNT_W
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             LOCK,
    input  logic             CLR_FAULT,
    output logic             PLL_RST_REQ,
    output logic [N_DOM-1:0] DOM_RST,
    output logic             READY,
    output logic             FAULT,
    output logic [7:0]       RELOCK_CNT,
    output logic [2:0]       STATE
);

    localparam int IDX_W = (N_DOM > 1) ? $clog2(N_DOM) : 1;
    localparam int RTY_W = $clog2(MAX_RETRY + 1);

    localparam logic [CNT_W-1:0] STABLE_LAST  = CNT_W'(LOCK_STABLE_CYC - 1);
    localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(LOCK_TIMEOUT_CYC - 1);
    localparam logic [CNT_W-1:0] STAGGER_LAST = CNT_W'(STAGGER_CYC - 1);
    localparam logic [CNT_W-1:0] PULSE_LAST   = CNT_W'(PLL_RST_CYC - 1);
    localparam logic [IDX_W-1:0] IDX_LAST     = IDX_W'(N_DOM - 1);
    localparam logic [RTY_W-1:0] RETRY_MAX    = RTY_W'(MAX_RETRY);

    logic w_lock_s;

    pll_state_e       r_state,   w_state_nxt;
    logic [CNT_W-1:0] r_cnt,     w_cnt_nxt;
    logic [CNT_W-1:0] r_stable,  w_stable_nxt;
    logic [IDX_W-1:0] r_idx,     w_idx_nxt;
    logic [RTY_W-1:0] r_retry,   w_retry_nxt;
    logic [7:0]       r_relock,  w_relock_nxt;
    logic [N_DOM-1:0] r_dom_rst, w_dom_rst_nxt;
    logic             r_ready,   w_ready_nxt;
    logic             r_fault,   w_fault_nxt;
    logic             r_req,     w_req_nxt;
    logic [RTY_W-1:0] w_retry_inc;

    sync_2ff #(.RST_VAL(1'b0)) u_lock_sync (
        .i_clk (CLK),
        .i_rst (RST),
        .i_d   (LOCK),
        .o_q   (w_lock_s)
    );

    assign w_retry_inc = r_retry + 1'b1;

    // NOTE: every next-state variable gets a default before the case so no
    // path leaves it unassigned and no latch is inferred.
    always_comb begin
        w_state_nxt   = r_state;
        w_cnt_nxt     = r_cnt;
        w_stable_nxt  = r_stable;
        w_idx_nxt     = r_idx;
        w_retry_nxt   = r_retry;
        w_relock_nxt  = r_relock;
        w_dom_rst_nxt = r_dom_rst;
        w_ready_nxt   = 1'b0;
        w_fault_nxt   = r_fault;
        w_req_nxt     = 1'b0;

        unique case (r_state)
            ST_WAIT_LOCK: begin
                w_dom_rst_nxt = '1;
                w_cnt_nxt     = r_cnt + 1'b1;
                w_stable_nxt  = w_lock_s ? r_stable + 1'b1 : '0;
                // Release is tested first so it wins a tie with the timeout.
                if (w_lock_s && (r_stable == STABLE_LAST)) begin
                    w_state_nxt  = ST_RELEASE;
                    w_cnt_nxt    = '0;
                    w_stable_nxt = '0;
                    w_idx_nxt    = '0;
                end else if (r_cnt == TIMEOUT_LAST) begin
                    w_state_nxt  = ST_PLL_RST;
                    w_cnt_nxt    = '0;
                    w_stable_nxt = '0;
                    w_req_nxt    = 1'b1;
                end
            end
            ST_RELEASE, ST_RUN: begin
                if (!w_lock_s) begin
                    w_state_nxt   = ST_WAIT_LOCK;
                    w_dom_rst_nxt = '1;
                    w_relock_nxt  = sat_inc8(r_relock);
                    w_cnt_nxt     = '0;
                    w_stable_nxt  = '0;
                    w_idx_nxt     = '0;
                end else if (r_state == ST_RUN) begin
                    w_ready_nxt = 1'b1;
                end else begin
                    w_cnt_nxt = r_cnt + 1'b1;
                    if (r_cnt == STAGGER_LAST) begin
                        w_cnt_nxt            = '0;
                        w_dom_rst_nxt[r_idx] = 1'b0;
                        w_idx_nxt            = r_idx + 1'b1;
                        if (r_idx == IDX_LAST) begin
                            w_state_nxt = ST_RUN;
                            w_idx_nxt   = '0;
                            w_retry_nxt = '0;
                        end
                    end
                end
            end
            ST_PLL_RST: begin
                w_dom_rst_nxt = '1;
                w_req_nxt     = 1'b1;
                w_cnt_nxt     = r_cnt + 1'b1;
                if (r_cnt == PULSE_LAST) begin
                    w_req_nxt   = 1'b0;
                    w_cnt_nxt   = '0;
                    w_retry_nxt = w_retry_inc;
                    if (w_retry_inc == RETRY_MAX) begin
                        w_state_nxt = ST_FAULT;
                        w_fault_nxt = 1'b1;
                    end else begin
                        w_state_nxt = ST_WAIT_LOCK;
                    end
                end
            end
            ST_FAULT: begin
                w_dom_rst_nxt = '1;
                w_fault_nxt   = 1'b1;
                if (CLR_FAULT) begin
                    w_state_nxt  = ST_WAIT_LOCK;
                    w_fault_nxt  = 1'b0;
                    w_retry_nxt  = '0;
                    w_cnt_nxt    = '0;
                    w_stable_nxt = '0;
                end
            end
            default: begin
                w_state_nxt   = ST_WAIT_LOCK;
                w_dom_rst_nxt = '1;
                w_cnt_nxt     = '0;
                w_stable_nxt  = '0;
            end
        endcase
    end

    // NOTE: state registers use non-blocking assignments so every flop
    // samples the pre-edge values computed above.
    always_ff @(posedge CLK) begin
        if (RST) begin
            r_state   <= ST_WAIT_LOCK;
            r_cnt     <= '0;
            r_stable  <= '0;
            r_idx     <= '0;
            r_retry   <= '0;
            r_relock  <= '0;
            r_dom_rst <= '1;
            r_ready   <= 1'b0;
            r_fault   <= 1'b0;
            r_req     <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_cnt     <= w_cnt_nxt;
            r_stable  <= w_stable_nxt;
            r_idx     <= w_idx_nxt;
            r_retry   <= w_retry_nxt;
            r_relock  <= w_relock_nxt;
            r_dom_rst <= w_dom_rst_nxt;
            r_ready   <= w_ready_nxt;
            r_fault   <= w_fault_nxt;
            r_req     <= w_req_nxt;
        end
    end

    assign PLL_RST_REQ = r_req;
    assign DOM_RST     = r_dom_rst;
    assign READY       = r_ready;
    assign FAULT       = r_fault;
    assign RELOCK_CNT  = r_relock;
    assign STATE       = r_state;

endmodule

// File: tb/tb_pll_lock_rst_seq.sv
// Directed bench for pll_lock_rst_seq with shortened timing parameters.
module tb_pll_lock_rst_seq;

    logic       clk = 1'b0;
    logic       rst;
    logic       lock;
    logic       clr_fault;
    logic       pll_rst_req;
    logic [3:0] dom_rst;
    logic       ready;
    logic       fault;
    logic [7:0] relock_cnt;
    logic [2:0] state;

    int n_cmp = 0;
    int n_mis = 0;

    pll_lock_rst_seq #(
        .N_DOM            (4),
        .LOCK_STABLE_CYC  (8),
        .STAGGER_CYC      (4),
        .LOCK_TIMEOUT_CYC (64),
        .PLL_RST_CYC      (8),
        .MAX_RETRY        (3),
        .CNT_W            (17)
    ) dut (
        .CLK         (clk),
        .RST         (rst),
        .LOCK        (lock),
        .CLR_FAULT   (clr_fault),
        .PLL_RST_REQ (pll_rst_req),
        .DOM_RST     (dom_rst),
        .READY       (ready),
        .FAULT       (fault),
        .RELOCK_CNT  (relock_cnt),
        .STATE       (state)
    );

    always #5 clk = ~clk;

    // Advance n rising edges, then settle 1 time unit past the last one.
    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_mis++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    initial begin
        rst       = 1'b1;
        lock      = 1'b0;
        clr_fault = 1'b0;
        step(3);
        check("rst_dom",    dom_rst,     4'hF);
        check("rst_req",    pll_rst_req, 1'b0);
        check("rst_ready",  ready,       1'b0);
        check("rst_fault",  fault,       1'b0);
        check("rst_relock", relock_cnt,  8'd0);
        check("rst_state",  state,       3'd0);

        // Bring-up: lock_s high from edge 2, release on edge 10, then 4-cycle stagger.
        rst  = 1'b0;
        lock = 1'b1;
        step(9);
        check("up_wait_state", state,   3'd0);
        check("up_wait_dom",   dom_rst, 4'hF);
        step(1);
        check("up_rel_state",  state,   3'd1);
        step(3);
        check("up_dom_hold",   dom_rst, 4'hF);
        step(1);
        check("up_dom0",       dom_rst, 4'hE);
        step(4);
        check("up_dom1",       dom_rst, 4'hC);
        step(4);
        check("up_dom2",       dom_rst, 4'h8);
        step(4);
        check("up_dom3",       dom_rst, 4'h0);
        check("up_run_state",  state,   3'd2);
        check("up_ready_lag",  ready,   1'b0);
        step(1);
        check("up_ready",      ready,   1'b1);

        // One-cycle lock drop in RUN: resets reassert on the third edge.
        lock = 1'b0;
        step(1);
        lock = 1'b1;
        check("loss_e1_dom",   dom_rst,    4'h0);
        check("loss_e1_ready", ready,      1'b1);
        step(1);
        check("loss_e2_state", state,      3'd2);
        step(1);
        check("loss_e3_dom",   dom_rst,    4'hF);
        check("loss_e3_ready", ready,      1'b0);
        check("loss_e3_state", state,      3'd0);
        check("loss_relock",   relock_cnt, 8'd1);
        step(7);
        check("reseq_wait",    state,      3'd0);
        step(1);
        check("reseq_rel",     state,      3'd1);
        step(4);
        check("reseq_dom0",    dom_rst,    4'hE);
        step(4);
        check("reseq_dom1",    dom_rst,    4'hC);

        // Reset while in RELEASE with two domains already out of reset.
        rst  = 1'b1;
        lock = 1'b0;
        step(1);
        check("midrst_dom",    dom_rst,    4'hF);
        check("midrst_relock", relock_cnt, 8'd0);
        check("midrst_state",  state,      3'd0);
        check("midrst_ready",  ready,      1'b0);
        step(2);

        // Glitchy lock: 5 high / 1 low never reaches 8 consecutive cycles.
        rst  = 1'b0;
        lock = 1'b1;
        for (int r = 0; r < 4; r++) begin
            step(5);
            lock = 1'b0;
            check("glitch_dom",   dom_rst, 4'hF);
            check("glitch_state", state,   3'd0);
            step(1);
            lock = 1'b1;
        end
        step(9);
        check("glitch_still_wait", state,   3'd0);
        step(1);
        check("glitch_rel",        state,   3'd1);
        step(4);
        check("glitch_dom0",       dom_rst, 4'hE);
        step(4);
        check("glitch_dom1",       dom_rst, 4'hC);
        step(8);
        check("glitch_dom3",       dom_rst, 4'h0);
        check("glitch_run",        state,   3'd2);
        step(1);
        check("glitch_ready",      ready,   1'b1);

        // CLR_FAULT outside FAULT must not disturb RUN.
        clr_fault = 1'b1;
        step(1);
        clr_fault = 1'b0;
        check("clr_in_run_state", state, 3'd2);
        check("clr_in_run_ready", ready, 1'b1);

        // Saturation: each loss re-sequences back to READY in 28 edges.
        for (int i = 0; i < 255; i++) begin
            lock = 1'b0;
            step(1);
            lock = 1'b1;
            step(27);
        end
        check("sat_255",       relock_cnt, 8'd255);
        check("sat_255_ready", ready,      1'b1);
        for (int i = 0; i < 45; i++) begin
            lock = 1'b0;
            step(1);
            lock = 1'b1;
            step(27);
        end
        check("sat_300",       relock_cnt, 8'd255);
        check("sat_300_state", state,      3'd2);
        check("sat_300_ready", ready,      1'b1);

        // Timeout and fault: lock held low, 64-cycle windows, 8-cycle pulses.
        lock = 1'b0;
        step(3);
        check("to_loss_state", state,       3'd0);
        check("to_relock_sat", relock_cnt,  8'd255);
        step(63);
        check("to1_pre_req",   pll_rst_req, 1'b0);
        check("to1_pre_state", state,       3'd0);
        step(1);
        check("to1_req",       pll_rst_req, 1'b1);
        check("to1_state",     state,       3'd3);
        check("to1_dom",       dom_rst,     4'hF);
        step(7);
        check("to1_req_last",  pll_rst_req, 1'b1);
        step(1);
        check("to1_req_end",   pll_rst_req, 1'b0);
        check("to1_back_wait", state,       3'd0);
        step(64);
        check("to2_req",       pll_rst_req, 1'b1);
        step(72);
        check("to3_req",       pll_rst_req, 1'b1);
        check("to3_state",     state,       3'd3);
        check("to3_no_fault",  fault,       1'b0);
        step(8);
        check("fault_set",     fault,       1'b1);
        check("fault_state",   state,       3'd4);
        check("fault_req",     pll_rst_req, 1'b0);
        check("fault_dom",     dom_rst,     4'hF);
        lock = 1'b1;
        step(20);
        check("fault_lock_ignored", state,  3'd4);
        clr_fault = 1'b1;
        step(1);
        clr_fault = 1'b0;
        check("clr_fault",     fault,       1'b0);
        check("clr_state",     state,       3'd0);
        check("clr_relock",    relock_cnt,  8'd255);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
